// File: rtl/ddr_arb_pkg.sv
// Shared constants for the DDR3 ping-pong page arbiter and the address
// generators on either side of it.
package ddr_arb_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ISSUE_WR = 2'd1;
    localparam logic [1:0] ST_ISSUE_RD = 2'd2;
    localparam logic [1:0] ST_SWAP     = 2'd3;

    localparam int PAGE_ONE_BASE = 1;
    localparam int PAGE_TWO_BASE = 11449;
    localparam int PAGE_SIZE     = 11448;

endpackage

// File: rtl/ddr_page_arbiter.sv
// Arbitrates the single DDR3 command port between the video writer and the
// block-order reader, and sequences the ping-pong page swap between them.
module ddr_page_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int PAGE_ONE   = PAGE_ONE_BASE,
    parameter int PAGE_TWO   = PAGE_TWO_BASE,
    parameter int STARVE_MAX = 4
) (
    input  logic              i_pix_clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_off,
    output logic              wr_ack,
    output logic              wr_stall,
    input  logic              frame_done,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    input  logic              rd_done,
    output logic              page_sel,
    output logic              cmd_valid,
    output logic              cmd_we,
    output logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_ready,
    output logic              overrun
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);

    logic [1:0]        r_state;
    logic [SC_W-1:0]   r_starve_cnt;
    logic              r_swap_pending;
    logic              r_rd_busy;
    logic              r_page_sel;
    logic              r_cmd_valid;
    logic              r_cmd_we;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic              r_wr_ack;
    logic              r_rd_ack;
    logic              r_overrun;

    logic              w_starve_ok;
    logic [ADDR_W-1:0] w_wr_base;
    logic [ADDR_W-1:0] w_wr_addr;

    assign w_starve_ok = (r_starve_cnt < SC_W'(STARVE_MAX));
    // page_sel names the page being read; the writer fills the other one
    assign w_wr_base   = r_page_sel ? ADDR_W'(PAGE_ONE) : ADDR_W'(PAGE_TWO);
    assign w_wr_addr   = w_wr_base + wr_off;

    always_ff @(posedge i_pix_clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_starve_cnt   <= '0;
            r_swap_pending <= 1'b0;
            r_rd_busy      <= 1'b0;
            r_page_sel     <= 1'b0;
            r_cmd_valid    <= 1'b0;
            r_cmd_we       <= 1'b0;
            r_cmd_addr     <= '0;
            r_wr_ack       <= 1'b0;
            r_rd_ack       <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_wr_ack  <= 1'b0;
            r_rd_ack  <= 1'b0;
            r_overrun <= frame_done && r_swap_pending;
            if (rd_done)
                r_rd_busy <= 1'b0;
            if (frame_done)
                r_swap_pending <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (r_swap_pending && !r_rd_busy) begin
                        r_state <= ST_SWAP;
                    end else if (rd_req && (!wr_req || w_starve_ok)) begin
                        r_state     <= ST_ISSUE_RD;
                        r_cmd_valid <= 1'b1;
                        r_cmd_we    <= 1'b0;
                        r_cmd_addr  <= rd_addr;
                    end else if (wr_req) begin
                        r_state     <= ST_ISSUE_WR;
                        r_cmd_valid <= 1'b1;
                        r_cmd_we    <= 1'b1;
                        r_cmd_addr  <= w_wr_addr;
                    end
                end
                ST_ISSUE_WR: begin
                    if (cmd_ready) begin
                        r_state      <= ST_IDLE;
                        r_cmd_valid  <= 1'b0;
                        r_wr_ack     <= 1'b1;
                        r_starve_cnt <= '0;
                    end
                end
                ST_ISSUE_RD: begin
                    if (cmd_ready) begin
                        r_state     <= ST_IDLE;
                        r_cmd_valid <= 1'b0;
                        r_rd_ack    <= 1'b1;
                        if (wr_req && w_starve_ok)
                            r_starve_cnt <= r_starve_cnt + 1'b1;
                    end
                end
                ST_SWAP: begin
                    // overrides same-cycle flag updates so a late frame_done cannot re-arm a swap
                    r_state        <= ST_IDLE;
                    r_page_sel     <= ~r_page_sel;
                    r_rd_busy      <= 1'b1;
                    r_swap_pending <= 1'b0;
                    r_starve_cnt   <= '0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wr_stall  = r_swap_pending;
    assign page_sel  = r_page_sel;
    assign cmd_valid = r_cmd_valid;
    assign cmd_we    = r_cmd_we;
    assign cmd_addr  = r_cmd_addr;
    assign wr_ack    = r_wr_ack;
    assign rd_ack    = r_rd_ack;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_ddr_page_arbiter.sv
// Directed and randomized bench for ddr_page_arbiter against a grant-level
// reference model of the arbitration and page-swap rules.
module tb_ddr_page_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_req = 1'b0;
    logic [15:0] wr_off = '0;
    logic        wr_ack;
    logic        wr_stall;
    logic        frame_done = 1'b0;
    logic        rd_req = 1'b0;
    logic [15:0] rd_addr = '0;
    logic        rd_ack;
    logic        rd_done = 1'b0;
    logic        page_sel;
    logic        cmd_valid;
    logic        cmd_we;
    logic [15:0] cmd_addr;
    logic        cmd_ready = 1'b0;
    logic        overrun;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    bit m_page, m_pend, m_busy;
    int m_starve;
    int last_wait;
    bit last_rd;
    logic [15:0] last_addr;

    always #5 clk = ~clk;

    ddr_page_arbiter dut (
        .i_pix_clk (clk),
        .rst       (rst),
        .wr_req    (wr_req),
        .wr_off    (wr_off),
        .wr_ack    (wr_ack),
        .wr_stall  (wr_stall),
        .frame_done(frame_done),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_ack    (rd_ack),
        .rd_done   (rd_done),
        .page_sel  (page_sel),
        .cmd_valid (cmd_valid),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_ready (cmd_ready),
        .overrun   (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_page = 0; m_pend = 0; m_busy = 0; m_starve = 0;
    endtask

    // Serve one grant for the requests currently driven; drops the winner's request.
    task automatic grant(input int stall);
        bit          exp_rd;
        logic [15:0] exp_addr;
        if (m_pend && !m_busy) begin
            m_page = !m_page; m_busy = 1; m_pend = 0; m_starve = 0;
        end
        exp_rd   = rd_req && (!wr_req || m_starve < STARVE_MAX);
        exp_addr = exp_rd ? rd_addr : 16'((m_page ? 1 : 11449) + int'(wr_off));
        last_wait = 0;
        while (!cmd_valid && last_wait < 12) begin
            @(negedge clk);
            last_wait++;
        end
        chk("cmd_valid_seen", cmd_valid, 1);
        chk("cmd_we", cmd_we, !exp_rd);
        chk("cmd_addr", cmd_addr, exp_addr);
        chk("page_sel_at_grant", page_sel, m_page);
        chk("wr_stall_at_grant", wr_stall, m_pend);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("addr_hold", cmd_addr, exp_addr);
            chk("no_ack_while_stalled", {rd_ack, wr_ack, cmd_valid}, 3'b001);
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        chk("ack", {rd_ack, wr_ack}, exp_rd ? 2'b10 : 2'b01);
        chk("cmd_valid_drop", cmd_valid, 0);
        last_rd   = exp_rd;
        last_addr = exp_addr;
        if (exp_rd) begin
            rd_req = 1'b0;
            if (wr_req && m_starve < STARVE_MAX) m_starve++;
        end else begin
            wr_req = 1'b0;
            m_starve = 0;
        end
    endtask

    // One-cycle frame_done / rd_done pulse while no request is active.
    task automatic pulse(input bit fd, input bit rdd);
        frame_done = fd;
        rd_done    = rdd;
        @(negedge clk);
        frame_done = 1'b0;
        rd_done    = 1'b0;
        chk("overrun", overrun, fd && m_pend);
        m_pend = m_pend | fd;
        if (rdd) m_busy = 0;
        chk("wr_stall_after_pulse", wr_stall, m_pend);
        repeat (3) @(negedge clk);
        if (m_pend && !m_busy) begin
            m_page = !m_page; m_busy = 1; m_pend = 0; m_starve = 0;
        end
        chk("page_sel_after_pulse", page_sel, m_page);
        chk("wr_stall_settled", wr_stall, m_pend);
        chk("overrun_single", overrun, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_outputs", {page_sel, cmd_valid, cmd_we, wr_ack, rd_ack, overrun, wr_stall}, 7'b0);
        chk("rst_cmd_addr", cmd_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        // first write lands in page 1 base while page_sel=0
        wr_req = 1'b1; wr_off = 16'd5;
        grant(0);
        chk("wr_latency", last_wait, 1);
        chk("wr_addr_11454", last_addr, 16'd11454);

        // continuous read+write contention: four reads, then one write
        rd_addr = 16'd1; wr_off = 16'd7;
        for (int i = 0; i < 10; i++) begin
            rd_req = 1'b1; wr_req = 1'b1;
            grant(0);
            chk("starve_pattern", last_rd, (i % 5) != 4);
            chk("starve_bound", m_starve <= STARVE_MAX, 1);
        end
        rd_req = 1'b0; wr_req = 1'b0;
        @(negedge clk);

        // swap with reader idle, next write targets base 1
        pulse(1, 0);
        chk("page_after_swap", page_sel, 1);
        wr_req = 1'b1; wr_off = 16'd5;
        grant(0);
        chk("wr_addr_page0", last_addr, 16'd6);

        // reader busy: swap waits for rd_done; second frame_done overruns
        pulse(1, 0);
        chk("page_held_busy", page_sel, 1);
        pulse(1, 0);
        pulse(0, 1);
        chk("page_after_rd_done", page_sel, 0);
        pulse(0, 1);
        pulse(1, 1);
        chk("page_same_cycle", page_sel, 1);
        pulse(0, 1);

        // long cmd_ready stall during a read
        rd_req = 1'b1; rd_addr = 16'($urandom);
        grant(10);

        // reset while a write command is outstanding
        wr_req = 1'b1; wr_off = 16'd3;
        repeat (2) @(negedge clk);
        chk("issue_wr_active", {cmd_valid, cmd_we}, 2'b11);
        #1 rst = 1'b1; cmd_ready = 1'b1;
        #1 chk("rst_mid_cmd", {page_sel, cmd_valid, cmd_we, wr_ack, rd_ack, overrun, wr_stall}, 7'b0);
        chk("rst_mid_addr", cmd_addr, 0);
        @(negedge clk);
        chk("rst_no_ack", wr_ack, 0);
        rst = 1'b0; wr_req = 1'b0; cmd_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("post_rst_idle", {wr_ack, cmd_valid}, 2'b00);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            if (!wr_req && !rd_req && $urandom_range(0, 3) == 0)
                pulse(1'($urandom), 1'($urandom));
            if (!wr_req && !m_pend && $urandom_range(0, 1) == 1) begin
                wr_req = 1'b1; wr_off = 16'($urandom);
            end
            if (!rd_req && $urandom_range(0, 1) == 1) begin
                rd_req = 1'b1; rd_addr = 16'($urandom);
            end
            if (wr_req || rd_req)
                grant(int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
